// File: rtl/turn_sequencer.sv
// rtl/turn_sequencer.sv - two-player turn scheduler: key-to-command, board handshake, turn timer, bomb budgets
module turn_sequencer #(
   parameter int CLK_HZ   = 100_000_000,
   parameter int TURN_SEC = 30,
   parameter int BOOMS    = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] p1_dir,
   input  logic       p1_place,
   input  logic       p1_boom,
   input  logic [3:0] p2_dir,
   input  logic       p2_place,
   input  logic       p2_boom,
   input  logic       start_k,
   input  logic       pause_k,
   output logic       cmd_valid,
   input  logic       cmd_ready,
   output logic       cmd_player,
   output logic [2:0] cmd_op,
   input  logic       place_done,
   input  logic [1:0] win,
   output logic [2:0] state,
   output logic       turn,
   output logic [5:0] time_left,
   output logic [1:0] booms1,
   output logic [1:0] booms2,
   output logic [1:0] winner,
   output logic       music_en
);

   localparam int         PW          = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
   localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_HZ - 1);
   localparam logic [5:0] TIME_RELOAD = 6'(TURN_SEC);
   localparam logic [1:0] BOOM_RELOAD = 2'(BOOMS);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_PLAY  = 3'd1,
      S_WAIT  = 3'd2,
      S_PAUSE = 3'd3,
      S_OVER  = 3'd4
   } state_t;

   state_t        state_q, state_d;
   logic          turn_q, turn_d;
   logic [5:0]    time_q, time_d;
   logic [PW-1:0] presc_q, presc_d;
   logic [1:0]    booms1_q, booms1_d;
   logic [1:0]    booms2_q, booms2_d;
   logic [1:0]    winner_q, winner_d;
   logic          cmd_valid_q, cmd_valid_d;
   logic          cmd_player_q, cmd_player_d;
   logic [2:0]    cmd_op_q, cmd_op_d;

   logic [3:0] act_dir;
   logic       act_place, act_boom;
   logic [1:0] act_booms;
   logic       key_hit;
   logic [2:0] key_op;
   logic       tick, expire;

   // Only the active player's keys are decoded; an empty bomb budget masks boom.
   always_comb begin
      act_dir   = turn_q ? p2_dir   : p1_dir;
      act_place = turn_q ? p2_place : p1_place;
      act_boom  = turn_q ? p2_boom  : p1_boom;
      act_booms = turn_q ? booms2_q : booms1_q;
      key_hit   = 1'b1;
      key_op    = 3'd0;
      if (act_boom && act_booms != 2'd0) key_op = 3'd5;
      else if (act_place)                key_op = 3'd4;
      else if (act_dir[3])               key_op = 3'd0;
      else if (act_dir[2])               key_op = 3'd1;
      else if (act_dir[1])               key_op = 3'd2;
      else if (act_dir[0])               key_op = 3'd3;
      else                               key_hit = 1'b0;
   end

   assign tick   = (presc_q == PRESC_MAX);
   assign expire = tick && (time_q == 6'd1);

   always_comb begin
      state_d      = state_q;
      turn_d       = turn_q;
      time_d       = time_q;
      presc_d      = presc_q;
      booms1_d     = booms1_q;
      booms2_d     = booms2_q;
      winner_d     = winner_q;
      cmd_valid_d  = cmd_valid_q;
      cmd_player_d = cmd_player_q;
      cmd_op_d     = cmd_op_q;
      unique case (state_q)
         S_IDLE: begin
            if (start_k) begin
               state_d  = S_PLAY;
               turn_d   = 1'b0;
               time_d   = TIME_RELOAD;
               presc_d  = '0;
               booms1_d = BOOM_RELOAD;
               booms2_d = BOOM_RELOAD;
               winner_d = 2'd0;
            end
         end
         S_PLAY: begin
            if (cmd_valid_q) begin
               if (cmd_ready) begin
                  cmd_valid_d = 1'b0;
                  if (cmd_op_q >= 3'd4) state_d = S_WAIT;
                  if (cmd_op_q == 3'd5) begin
                     if (turn_q) booms2_d = booms2_q - 2'd1;
                     else        booms1_d = booms1_q - 2'd1;
                  end
               end
            end else if (pause_k) begin
               state_d = S_PAUSE;
            end else begin
               if (tick) begin
                  presc_d = '0;
                  if (expire) begin
                     turn_d = ~turn_q;
                     time_d = TIME_RELOAD;
                  end else begin
                     time_d = time_q - 6'd1;
                  end
               end else begin
                  presc_d = presc_q + PW'(1);
               end
               // A forfeit in the same cycle swallows the key.
               if (key_hit && !expire) begin
                  cmd_valid_d  = 1'b1;
                  cmd_player_d = turn_q;
                  cmd_op_d     = key_op;
               end
            end
         end
         S_WAIT: begin
            if (place_done) begin
               if (win != 2'd0) begin
                  state_d  = S_OVER;
                  winner_d = win;
               end else begin
                  state_d = S_PLAY;
                  turn_d  = ~turn_q;
                  time_d  = TIME_RELOAD;
                  presc_d = '0;
               end
            end
         end
         S_PAUSE, S_OVER: begin
            if (start_k) begin
               state_d     = S_IDLE;
               turn_d      = 1'b0;
               time_d      = TIME_RELOAD;
               presc_d     = '0;
               booms1_d    = BOOM_RELOAD;
               booms2_d    = BOOM_RELOAD;
               winner_d    = 2'd0;
               cmd_valid_d = 1'b0;
            end else if (pause_k && state_q == S_PAUSE) begin
               state_d = S_PLAY;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         turn_q       <= 1'b0;
         time_q       <= TIME_RELOAD;
         presc_q      <= '0;
         booms1_q     <= BOOM_RELOAD;
         booms2_q     <= BOOM_RELOAD;
         winner_q     <= 2'd0;
         cmd_valid_q  <= 1'b0;
         cmd_player_q <= 1'b0;
         cmd_op_q     <= 3'd0;
      end else begin
         state_q      <= state_d;
         turn_q       <= turn_d;
         time_q       <= time_d;
         presc_q      <= presc_d;
         booms1_q     <= booms1_d;
         booms2_q     <= booms2_d;
         winner_q     <= winner_d;
         cmd_valid_q  <= cmd_valid_d;
         cmd_player_q <= cmd_player_d;
         cmd_op_q     <= cmd_op_d;
      end
   end

   assign state      = state_q;
   assign turn       = turn_q;
   assign time_left  = time_q;
   assign booms1     = booms1_q;
   assign booms2     = booms2_q;
   assign winner     = winner_q;
   assign cmd_valid  = cmd_valid_q;
   assign cmd_player = cmd_player_q;
   assign cmd_op     = cmd_op_q;
   assign music_en   = (state_q == S_PLAY) || (state_q == S_WAIT);

endmodule

// File: tb/tb_turn_sequencer.sv
// tb/tb_turn_sequencer.sv - randomized scoreboard bench for turn_sequencer against a behavioural game model
module tb_turn_sequencer;
   localparam int CLK_HZ   = 10;
   localparam int TURN_SEC = 3;
   localparam int BOOMS    = 1;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] p1_dir, p2_dir;
   logic       p1_place, p1_boom, p2_place, p2_boom;
   logic       start_k, pause_k, cmd_ready, place_done;
   logic [1:0] win;
   logic       cmd_valid, cmd_player, turn, music_en;
   logic [2:0] cmd_op, state;
   logic [5:0] time_left;
   logic [1:0] booms1, booms2, winner;

   always #5 clk = ~clk;

   turn_sequencer #(.CLK_HZ(CLK_HZ), .TURN_SEC(TURN_SEC), .BOOMS(BOOMS)) dut (
      .clk(clk), .rst(rst),
      .p1_dir(p1_dir), .p1_place(p1_place), .p1_boom(p1_boom),
      .p2_dir(p2_dir), .p2_place(p2_place), .p2_boom(p2_boom),
      .start_k(start_k), .pause_k(pause_k),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_player(cmd_player), .cmd_op(cmd_op),
      .place_done(place_done), .win(win),
      .state(state), .turn(turn), .time_left(time_left),
      .booms1(booms1), .booms2(booms2), .winner(winner), .music_en(music_en)
   );

   int checks   = 0;
   int failures = 0;

   typedef struct {
      int player;
      int op;
   } cmd_t;
   cmd_t exp_q[$];

   // Game model: time is tracked as active cycles elapsed in the turn, not as a prescaler.
   int m_state, m_turn, m_pend, m_pop, m_pplayer, m_cyc, m_winner;
   int m_booms[2];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d t=%0t", name, got, exp, $time);
      end
   endtask

   task automatic model_reload();
      m_turn = 0; m_cyc = 0; m_winner = 0; m_pend = 0;
      m_booms[0] = BOOMS; m_booms[1] = BOOMS;
   endtask

   task automatic model_reset();
      model_reload();
      m_state = 0; m_pop = 0; m_pplayer = 0;
      exp_q.delete();
   endtask

   function automatic int key_op();
      logic [3:0] d;
      logic pl, bm;
      d  = m_turn ? p2_dir : p1_dir;
      pl = m_turn ? p2_place : p1_place;
      bm = m_turn ? p2_boom : p1_boom;
      if (bm && m_booms[m_turn] > 0) return 5;
      if (pl) return 4;
      for (int i = 0; i < 4; i++)
         if (d[3-i]) return i;
      return -1;
   endfunction

   task automatic model_step();
      int k;
      case (m_state)
         0: if (start_k) begin m_state = 1; model_reload(); end
         1: begin
            if (m_pend != 0) begin
               if (cmd_ready) begin
                  m_pend = 0;
                  if (m_pop >= 4) m_state = 2;
                  if (m_pop == 5) m_booms[m_pplayer]--;
               end
            end else if (pause_k) begin
               m_state = 3;
            end else if (m_cyc + 1 == TURN_SEC * CLK_HZ) begin
               m_turn ^= 1; m_cyc = 0;
            end else begin
               m_cyc++;
               k = key_op();
               if (k >= 0) begin
                  m_pend = 1; m_pop = k; m_pplayer = m_turn;
                  exp_q.push_back('{m_turn, k});
               end
            end
         end
         2: if (place_done) begin
            if (win != 2'd0) begin m_state = 4; m_winner = win; end
            else begin m_turn ^= 1; m_cyc = 0; m_state = 1; end
         end
         3: if (start_k) begin m_state = 0; model_reload(); end
            else if (pause_k) m_state = 1;
         default: if (start_k) begin m_state = 0; model_reload(); end
      endcase
   endtask

   task automatic check_status();
      check("state", state, m_state);
      check("turn", turn, m_turn);
      check("time_left", time_left, TURN_SEC - m_cyc / CLK_HZ);
      check("booms1", booms1, m_booms[0]);
      check("booms2", booms2, m_booms[1]);
      check("winner", winner, m_winner);
      check("music_en", music_en, (m_state == 1 || m_state == 2) ? 1 : 0);
      check("cmd_valid", cmd_valid, m_pend);
      if (m_pend != 0) begin
         check("cmd_player_hold", cmd_player, m_pplayer);
         check("cmd_op_hold", cmd_op, m_pop);
      end
   endtask

   function automatic bit chance(input int pct);
      return $urandom_range(99, 0) < pct;
   endfunction

   task automatic idle_inputs();
      p1_dir = 4'd0; p2_dir = 4'd0;
      p1_place = 0; p1_boom = 0; p2_place = 0; p2_boom = 0;
      start_k = 0; pause_k = 0; cmd_ready = 0; place_done = 0; win = 2'd0;
   endtask

   task automatic rand_inputs(input int key_pct, input int ready_pct, input bit multi);
      idle_inputs();
      if (chance(key_pct)) p1_dir = multi ? 4'($urandom_range(15, 1)) : 4'(1 << $urandom_range(3, 0));
      if (chance(key_pct)) p2_dir = multi ? 4'($urandom_range(15, 1)) : 4'(1 << $urandom_range(3, 0));
      p1_place   = chance(key_pct / 2);
      p2_place   = chance(key_pct / 2);
      p1_boom    = chance(key_pct / 2);
      p2_boom    = chance(key_pct / 2);
      start_k    = chance(2);
      pause_k    = chance(3);
      cmd_ready  = chance(ready_pct);
      place_done = chance(25);
      win        = chance(15) ? 2'($urandom_range(3, 1)) : 2'd0;
   endtask

   // Async reset asserted mid-cycle must take effect before the next clock edge.
   task automatic async_reset();
      idle_inputs();
      rst = 1'b1;
      #1;
      check("async_state", state, 0);
      check("async_cmd_valid", cmd_valid, 0);
      check("async_time_left", time_left, TURN_SEC);
      @(posedge clk); #2;
      rst = 1'b0;
      model_reset();
   endtask

   initial begin : monitor
      cmd_t e;
      forever begin
         @(negedge clk);
         if (rst === 1'b0 && cmd_valid === 1'b1 && cmd_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
               checks++; failures++;
               $display("FAIL cmd_unexpected got=op%0d exp=none t=%0t", cmd_op, $time);
            end else begin
               e = exp_q.pop_front();
               check("cmd_player", cmd_player, e.player);
               check("cmd_op", cmd_op, e.op);
            end
         end
      end
   end

   initial begin
      int key_pct[3]   = '{10, 1, 50};
      int ready_pct[3] = '{60, 70, 30};
      idle_inputs();
      rst = 1'b1;
      model_reset();
      repeat (2) @(posedge clk);
      #2;
      check_status();
      check("reset_cmd_player", cmd_player, 0);
      check("reset_cmd_op", cmd_op, 0);
      rst = 1'b0;
      for (int ph = 0; ph < 3; ph++) begin
         for (int c = 0; c < 3000; c++) begin
            check_status();
            if (chance(1) && $urandom_range(4, 0) == 0) begin
               async_reset();
            end else begin
               rand_inputs(key_pct[ph], ready_pct[ph], ph == 2);
               model_step();
               @(posedge clk); #2;
            end
         end
      end
      check_status();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
